// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - program loader and run/step sequencer for the fetch stage
module fetch_sequencer #(
    parameter int              NB         = 32,
    parameter int              TAM_I      = 256,
    parameter logic [NB-1:0]   HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [1:0]    i_cmd,
    input  logic          i_cmd_valid,
    input  logic [7:0]    i_byte,
    input  logic          i_byte_valid,
    output logic          o_byte_ready,
    input  logic [NB-1:0] i_instruction,
    input  logic          i_stall,
    output logic          o_imem_we,
    output logic [NB-1:0] o_imem_addr,
    output logic [NB-1:0] o_imem_data,
    output logic          o_step,
    output logic          o_pc_write,
    output logic [2:0]    o_state,
    output logic          o_loaded,
    output logic          o_halted,
    output logic [NB-1:0] o_cycle_count
);

    localparam int BPW = NB / 8;
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

    localparam logic [1:0] CMD_LOAD  = 2'b00;
    localparam logic [1:0] CMD_RUN   = 2'b01;
    localparam logic [1:0] CMD_STEP  = 2'b10;
    localparam logic [1:0] CMD_ABORT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_STEP = 3'd3,
        S_HALT = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] byte_cnt;
    logic [NB-9:0] partial;
    logic [NB-1:0] wr_addr;
    logic [NB-1:0] cycle_cnt;
    logic [NB-1:0] word_nxt;
    logic          cmd_load, cmd_run, cmd_step, cmd_abort;
    logic          halt_in, byte_fire, start_load, load_done;

    assign cmd_load   = i_cmd_valid && (i_cmd == CMD_LOAD);
    assign cmd_run    = i_cmd_valid && (i_cmd == CMD_RUN);
    assign cmd_step   = i_cmd_valid && (i_cmd == CMD_STEP);
    assign cmd_abort  = i_cmd_valid && (i_cmd == CMD_ABORT);
    assign halt_in    = (i_instruction == HALT_INSTR);
    assign byte_fire  = i_byte_valid && o_byte_ready;
    assign start_load = cmd_load && (state == S_IDLE || state == S_HALT);
    assign word_nxt   = {partial, i_byte};

    // Load finishes in the cycle the final write is visible on the memory port.
    assign load_done  = (state == S_LOAD) && o_imem_we &&
                        ((o_imem_data == HALT_INSTR) || (o_imem_addr == NB'(TAM_I - 4)));

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (cmd_abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_load)      state_nxt = S_LOAD;
                    else if (cmd_run)  state_nxt = S_RUN;
                    else if (cmd_step) state_nxt = S_STEP;
                end
                S_LOAD:  if (load_done) state_nxt = S_IDLE;
                S_RUN:   if (halt_in)   state_nxt = S_HALT;
                S_STEP:  state_nxt = halt_in ? S_HALT : S_IDLE;
                S_HALT:  if (cmd_load)  state_nxt = S_LOAD;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_step       = 1'b0;
        o_byte_ready = 1'b0;
        o_halted     = 1'b0;
        case (state)
            S_LOAD:         o_byte_ready = 1'b1;
            S_RUN, S_STEP:  o_step       = !halt_in;
            S_HALT:         o_halted     = 1'b1;
            default:        ;
        endcase
        o_pc_write = o_step & ~i_stall;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            byte_cnt    <= '0;
            partial     <= '0;
            wr_addr     <= '0;
            o_imem_we   <= 1'b0;
            o_imem_addr <= '0;
            o_imem_data <= '0;
            o_loaded    <= 1'b0;
            cycle_cnt   <= '0;
        end else begin
            o_imem_we <= 1'b0;
            if (cmd_abort) begin
                byte_cnt <= '0;
            end else if (start_load) begin
                byte_cnt <= '0;
                wr_addr  <= '0;
                o_loaded <= 1'b0;
            end else if (load_done) begin
                byte_cnt <= '0;
                o_loaded <= 1'b1;
            end else if (state == S_LOAD && byte_fire) begin
                partial  <= word_nxt[NB-9:0];
                byte_cnt <= byte_cnt + 1'b1;
                if (byte_cnt == CW'(BPW - 1)) begin
                    o_imem_we   <= 1'b1;
                    o_imem_data <= word_nxt;
                    o_imem_addr <= wr_addr;
                    wr_addr     <= wr_addr + NB'(4);
                end
            end

            if (start_load)  cycle_cnt <= '0;
            else if (o_step) cycle_cnt <= cycle_cnt + 1'b1;
        end
    end

    assign o_state       = state;
    assign o_cycle_count = cycle_cnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [1:0]  C_LOAD = 2'b00, C_RUN = 2'b01, C_STEP = 2'b10, C_ABORT = 2'b11;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [1:0]  i_cmd;
    logic        i_cmd_valid;
    logic [7:0]  i_byte;
    logic        i_byte_valid;
    logic        o_byte_ready;
    logic [31:0] i_instruction;
    logic        i_stall;
    logic        o_imem_we;
    logic [31:0] o_imem_addr;
    logic [31:0] o_imem_data;
    logic        o_step;
    logic        o_pc_write;
    logic [2:0]  o_state;
    logic        o_loaded;
    logic        o_halted;
    logic [31:0] o_cycle_count;

    fetch_sequencer #(.NB(32), .TAM_I(256), .HALT_INSTR(32'hFFFF_FFFF)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_cmd(i_cmd), .i_cmd_valid(i_cmd_valid),
        .i_byte(i_byte), .i_byte_valid(i_byte_valid), .o_byte_ready(o_byte_ready),
        .i_instruction(i_instruction), .i_stall(i_stall), .o_imem_we(o_imem_we),
        .o_imem_addr(o_imem_addr), .o_imem_data(o_imem_data), .o_step(o_step),
        .o_pc_write(o_pc_write), .o_state(o_state), .o_loaded(o_loaded),
        .o_halted(o_halted), .o_cycle_count(o_cycle_count)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0]  bq[$];
    logic [63:0] exp_w[$];
    logic [63:0] cap[$];

    always @(negedge i_clk) if (i_reset && o_imem_we) cap.push_back({o_imem_addr, o_imem_data});

    typedef struct {
        logic [1:0]  cmd;
        logic        cv;
        logic [31:0] instr;
        logic        stall;
        logic [2:0]  st;
        logic        step;
        logic        pcw;
        logic [31:0] cnt;
    } vec_t;
    vec_t tbl[18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic cmd(input logic [1:0] c);
        i_cmd = c;
        i_cmd_valid = 1'b1;
        tick();
        i_cmd_valid = 1'b0;
    endtask

    // Reference: group bytes big-endian into words, stop after a halt word or the last slot.
    task automatic model_load();
        logic [31:0] word;
        exp_w = {};
        for (int k = 0; 4 * k + 3 < bq.size(); k++) begin
            word = {bq[4*k], bq[4*k+1], bq[4*k+2], bq[4*k+3]};
            exp_w.push_back({32'(4 * k), word});
            if (word == HALT || 4 * k == 252) break;
        end
    endtask

    task automatic stream(input bit gaps, output int acc);
        int guard;
        acc = 0;
        guard = 0;
        while (acc < bq.size() && guard < 5000) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                i_byte_valid = 1'b0;
            end else begin
                i_byte_valid = 1'b1;
                i_byte = bq[acc];
            end
            @(negedge i_clk);
            if (i_byte_valid && !o_byte_ready) break;
            if (i_byte_valid) acc++;
            guard++;
            tick();
        end
        i_byte_valid = 1'b0;
    endtask

    task automatic cmp_writes(input string tag);
        chk({tag, " nwrites"}, 64'(cap.size()), 64'(exp_w.size()));
        for (int i = 0; i < cap.size() && i < exp_w.size(); i++)
            chk($sformatf("%s write%0d", tag, i), cap[i], exp_w[i]);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (o_state != 3'd0 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, " reached idle"}, 64'(o_state), 64'd0);
    endtask

    initial begin
        int acc, nstep, npcw, exp_pcw, bad, n, hpos;
        logic stl;

        i_reset = 1'b0; i_cmd = 2'b00; i_cmd_valid = 1'b0; i_byte = 8'h00;
        i_byte_valid = 1'b0; i_instruction = 32'h0; i_stall = 1'b0;

        tbl[0]  = '{C_STEP,  1, 32'h0, 0, 3'd0, 0, 0, 0};
        tbl[1]  = '{C_LOAD,  0, 32'h1, 0, 3'd3, 1, 1, 0};
        tbl[2]  = '{C_STEP,  1, 32'h1, 1, 3'd0, 0, 0, 1};
        tbl[3]  = '{C_LOAD,  0, 32'h2, 1, 3'd3, 1, 0, 1};
        tbl[4]  = '{C_STEP,  1, 32'h2, 0, 3'd0, 0, 0, 2};
        tbl[5]  = '{C_LOAD,  0, 32'h3, 0, 3'd3, 1, 1, 2};
        tbl[6]  = '{C_LOAD,  0, 32'h3, 0, 3'd0, 0, 0, 3};
        tbl[7]  = '{C_RUN,   1, 32'h5, 0, 3'd0, 0, 0, 3};
        tbl[8]  = '{C_STEP,  1, 32'h5, 0, 3'd2, 1, 1, 3};
        tbl[9]  = '{C_LOAD,  0, 32'h5, 1, 3'd2, 1, 0, 4};
        tbl[10] = '{C_ABORT, 1, 32'h5, 0, 3'd2, 1, 1, 5};
        tbl[11] = '{C_LOAD,  0, 32'h5, 0, 3'd0, 0, 0, 6};
        tbl[12] = '{C_STEP,  1, 32'h5, 0, 3'd0, 0, 0, 6};
        tbl[13] = '{C_LOAD,  0, HALT,  0, 3'd3, 0, 0, 6};
        tbl[14] = '{C_RUN,   1, HALT,  0, 3'd4, 0, 0, 6};
        tbl[15] = '{C_STEP,  1, 32'h0, 0, 3'd4, 0, 0, 6};
        tbl[16] = '{C_ABORT, 1, 32'h0, 0, 3'd4, 0, 0, 6};
        tbl[17] = '{C_LOAD,  0, 32'h0, 0, 3'd0, 0, 0, 6};

        // Reset state
        tick(); tick();
        chk("reset state", 64'(o_state), 64'd0);
        chk("reset ready/we/step", {o_byte_ready, o_imem_we, o_step, o_pc_write, o_loaded, o_halted}, 64'd0);
        chk("reset count", 64'(o_cycle_count), 64'd0);
        i_reset = 1'b1;
        tick();

        // Example program: two words, the second one halts
        cmd(C_LOAD);
        chk("load state", 64'(o_state), 64'd1);
        cap = {};
        bq = {8'h20, 8'h08, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        model_load();
        stream(1'b0, acc);
        chk("ex accepted", 64'(acc), 64'd8);
        @(negedge i_clk);
        chk("ex we on 2nd write", {o_imem_we, o_imem_addr, o_imem_data}, {1'b1, 32'd4, HALT});
        chk("ex still load", 64'(o_state), 64'd1);
        tick();
        @(negedge i_clk);
        chk("ex idle+loaded", {o_state, o_loaded, o_imem_we}, {3'd0, 1'b1, 1'b0});
        tick();
        cmp_writes("ex");

        // 256 non-halt bytes back to back fill the whole memory
        cmd(C_LOAD);
        chk("full loaded cleared", 64'(o_loaded), 64'd0);
        cap = {};
        bq = {};
        for (int i = 0; i < 256; i++) bq.push_back(8'($urandom_range(0, 254)));
        model_load();
        stream(1'b0, acc);
        chk("full accepted", 64'(acc), 64'd256);
        wait_idle("full");
        chk("full loaded", 64'(o_loaded), 64'd1);
        bad = 0;
        foreach (cap[i]) if (cap[i][63:32] >= 256) bad++;
        chk("full addr range", 64'(bad), 64'd0);
        cmp_writes("full");

        // Random programs with gaps, halt word at a random position
        for (int it = 0; it < 4; it++) begin
            hpos = $urandom_range(0, 12);
            bq = {};
            for (int w = 0; w < hpos; w++) begin
                bq.push_back(8'($urandom_range(0, 254)));
                for (int b = 0; b < 3; b++) bq.push_back(8'($urandom));
            end
            for (int b = 0; b < 4; b++) bq.push_back(8'hFF);
            for (int b = 0; b < 6; b++) bq.push_back(8'($urandom));
            model_load();
            cmd(C_LOAD);
            cap = {};
            stream(1'b1, acc);
            wait_idle($sformatf("rnd%0d", it));
            chk($sformatf("rnd%0d loaded", it), 64'(o_loaded), 64'd1);
            cmp_writes($sformatf("rnd%0d", it));
        end

        // RUN for 10 cycles, then halt (count cleared by the previous LOAD)
        i_instruction = 32'h1234_5678;
        cmd(C_RUN);
        nstep = 0;
        for (int i = 0; i < 10; i++) begin
            i_instruction = $urandom & 32'h7FFF_FFFF;
            @(negedge i_clk);
            if (o_step) nstep++;
            tick();
        end
        chk("run10 steps", 64'(nstep), 64'd10);
        i_instruction = HALT;
        @(negedge i_clk);
        chk("run10 halt cycle step", {o_step, o_pc_write}, 64'd0);
        tick();
        @(negedge i_clk);
        chk("run10 halted", {o_state, o_halted}, {3'd4, 1'b1});
        chk("run10 count", 64'(o_cycle_count), 64'd10);
        tick();
        i_instruction = 32'h0;

        // Leave HALT via LOAD (clears count), then ABORT to IDLE
        cmd(C_LOAD);
        cmd(C_ABORT);

        // Table: STEP x3 with stall on the 2nd, RUN/ABORT, STEP into halt, HALT command filtering
        for (int i = 0; i < 18; i++) begin
            i_cmd = tbl[i].cmd;
            i_cmd_valid = tbl[i].cv;
            i_instruction = tbl[i].instr;
            i_stall = tbl[i].stall;
            @(negedge i_clk);
            chk($sformatf("tbl%0d state", i), 64'(o_state), 64'(tbl[i].st));
            chk($sformatf("tbl%0d step/pcw", i), {o_step, o_pc_write}, {tbl[i].step, tbl[i].pcw});
            chk($sformatf("tbl%0d count", i), 64'(o_cycle_count), 64'(tbl[i].cnt));
            tick();
        end
        i_cmd_valid = 1'b0;
        i_stall = 1'b0;

        // ABORT mid-word drops the partial word
        cmd(C_LOAD);
        cap = {};
        bq = {8'hAA, 8'hBB};
        stream(1'b0, acc);
        cmd(C_ABORT);
        cmd(C_LOAD);
        bq = {8'h11, 8'h22, 8'h33, 8'h44};
        stream(1'b0, acc);
        tick(); tick();
        chk("abort nwrites", 64'(cap.size()), 64'd1);
        if (cap.size() > 0) chk("abort write", cap[0], {32'd0, 32'h1122_3344});

        // RUN ignored while in LOAD
        cmd(C_RUN);
        @(negedge i_clk);
        chk("run in load ignored", {o_state, o_step}, {3'd1, 1'b0});
        tick();
        cmd(C_ABORT);

        // Random RUN lengths with random stalls
        for (int it = 0; it < 3; it++) begin
            n = $urandom_range(1, 30);
            cmd(C_LOAD);
            cmd(C_ABORT);
            cmd(C_RUN);
            nstep = 0; npcw = 0; exp_pcw = 0;
            for (int i = 0; i < n; i++) begin
                stl = 1'($urandom);
                i_stall = stl;
                i_instruction = $urandom & 32'hFFFF_FFFE;
                if (!stl) exp_pcw++;
                @(negedge i_clk);
                if (o_step) nstep++;
                if (o_pc_write) npcw++;
                tick();
            end
            i_instruction = HALT;
            tick();
            i_stall = 1'b0;
            @(negedge i_clk);
            chk($sformatf("rrun%0d steps", it), 64'(nstep), 64'(n));
            chk($sformatf("rrun%0d pcw", it), 64'(npcw), 64'(exp_pcw));
            chk($sformatf("rrun%0d count", it), 64'(o_cycle_count), 64'(n));
            chk($sformatf("rrun%0d halted", it), 64'(o_halted), 64'd1);
            tick();
            i_instruction = 32'h0;
        end

        // Asynchronous reset in the middle of RUN
        cmd(C_LOAD);
        bq = {8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        stream(1'b0, acc);
        wait_idle("pre-reset");
        i_instruction = 32'h5;
        cmd(C_RUN);
        tick(); tick();
        #2 i_reset = 1'b0;
        #1;
        chk("rst state", 64'(o_state), 64'd0);
        chk("rst flags", {o_byte_ready, o_imem_we, o_step, o_pc_write, o_loaded, o_halted}, 64'd0);
        chk("rst regs", {o_imem_addr, o_imem_data}, 64'd0);
        chk("rst count", 64'(o_cycle_count), 64'd0);
        tick();
        #2 i_reset = 1'b1;
        tick();
        @(negedge i_clk);
        chk("post-rst idle", {o_state, o_step, o_imem_we}, 64'd0);
        chk("post-rst count", 64'(o_cycle_count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
